// File: rtl/mag_stats_pkg.sv
// Shared constants and types for the magnitude window statistics block.
// Holds default widths, the {peak, mean} record and FSM state encodings.
package mag_stats_pkg;

  localparam int MAG_DATA_W    = 8;
  localparam int MAG_WIN_LOG2  = 3;
  localparam int MAG_FIFO_LOG2 = 2;

  typedef struct packed {
    logic [MAG_DATA_W-1:0] peak;
    logic [MAG_DATA_W-1:0] mean;
  } mag_rec_t;

  typedef enum logic {
    WIN_FILL,
    WIN_LAST
  } win_state_t;

  typedef enum logic {
    AL_IDLE,
    AL_ALARM
  } alarm_state_t;

endpackage

// File: rtl/mag_stats_fifo.sv
// Synchronous record FIFO with wrap-bit pointers and a registered head.
// A push that finds the FIFO full is accepted only if a pop frees a slot.
module mag_stats_fifo
  import mag_stats_pkg::*;
#(
  parameter int W  = 2 * MAG_DATA_W,
  parameter int AW = MAG_FIFO_LOG2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_req_i,
  output logic         valid_o,
  output logic [W-1:0] head_o,
  output logic         drop_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [AW:0]   rd_nxt;
  logic [W-1:0]  head_q, head_d;
  logic          empty, full;
  logic          pop, wr_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop    = !empty && pop_req_i;
  assign wr_ok  = push_i && (!full || pop);
  assign drop_o = push_i && full && !pop;
  assign rd_nxt = rd_q + 1'b1;

  assign valid_o = !empty;
  assign head_o  = head_q;

  // Pointer advance and next head value after this edge's push/pop.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    head_d = head_q;
    if (wr_ok) wr_d = wr_q + 1'b1;
    if (pop) begin
      rd_d = rd_nxt;
      if (rd_nxt != wr_q) begin
        head_d = mem_q[rd_nxt[AW-1:0]];
      end else if (wr_ok) begin
        head_d = wdata_i;
      end
    end else if (empty && wr_ok) begin
      head_d = wdata_i;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  // Pointers and head register; clr empties and zeroes the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else if (clr_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/mag_window_stats.sv
// Per-window peak/mean of a magnitude stream, queued for a slow reader.
// Define MAG_STATS_ALARM_EN to add the thr_hi/thr_lo hysteresis alarm.
module mag_window_stats
  import mag_stats_pkg::*;
#(
  parameter int DATA_W    = MAG_DATA_W,
  parameter int WIN_LOG2  = MAG_WIN_LOG2,
  parameter int FIFO_LOG2 = MAG_FIFO_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_peak,
  output logic [DATA_W-1:0]   out_mean,
  output logic [WIN_LOG2-1:0] win_cnt,
  output logic                overflow
`ifdef MAG_STATS_ALARM_EN
  ,
  input  logic [DATA_W-1:0]   thr_hi,
  input  logic [DATA_W-1:0]   thr_lo,
  output logic                alarm
`endif
);

  localparam int SW = DATA_W + WIN_LOG2;

  logic [SW-1:0]       sum_q, sum_d, sum_acc;
  logic [DATA_W-1:0]   peak_q, peak_d, peak_acc;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic                ovf_q;
  logic                accept, push, drop;
  logic [2*DATA_W-1:0] rec, head;
  win_state_t          win_st;

  assign accept = ena && in_valid;

  // Window FSM: state decoded from the sample count; LAST closes a window.
  always_comb begin
    win_st   = (cnt_q == '1) ? WIN_LAST : WIN_FILL;
    sum_acc  = sum_q + SW'(in_data);
    peak_acc = (in_data > peak_q) ? in_data : peak_q;
    rec      = {peak_acc, sum_acc[SW-1:WIN_LOG2]};
    sum_d    = sum_q;
    peak_d   = peak_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    if (accept) begin
      unique case (win_st)
        WIN_FILL: begin
          sum_d  = sum_acc;
          peak_d = peak_acc;
          cnt_d  = cnt_q + 1'b1;
        end
        WIN_LAST: begin
          push   = !clr;
          sum_d  = '0;
          peak_d = '0;
          cnt_d  = '0;
        end
      endcase
    end
  end

  // Accumulator, window count and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      peak_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (clr) begin
      sum_q  <= '0;
      peak_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      peak_q <= peak_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_q | drop;
    end
  end

  mag_stats_fifo #(
    .W  (2 * DATA_W),
    .AW (FIFO_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .push_i    (push),
    .wdata_i   (rec),
    .pop_req_i (out_ready),
    .valid_o   (out_valid),
    .head_o    (head),
    .drop_o    (drop)
  );

  assign out_peak = head[2*DATA_W-1:DATA_W];
  assign out_mean = head[DATA_W-1:0];
  assign win_cnt  = cnt_q;
  assign overflow = ovf_q;

`ifdef MAG_STATS_ALARM_EN
  alarm_state_t al_q, al_d;

  // Hysteresis next state, evaluated on every accepted sample.
  always_comb begin
    al_d = al_q;
    unique case (al_q)
      AL_IDLE:
        if (accept && in_data >= thr_hi) al_d = AL_ALARM;
      AL_ALARM:
        if (accept && in_data < thr_lo) al_d = AL_IDLE;
    endcase
  end

  // Alarm state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   al_q <= AL_IDLE;
    else if (clr) al_q <= AL_IDLE;
    else          al_q <= al_d;
  end

  assign alarm = (al_q == AL_ALARM);
`endif

endmodule

// File: tb/tb_mag_window_stats.sv
// Self-checking bench: directed vector table, corner sequences and
// randomized traffic against a queue-based window/FIFO model.
module tb_mag_window_stats;
  import mag_stats_pkg::*;

  localparam int N = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_peak;
  logic [7:0] out_mean;
  logic [2:0] win_cnt;
  logic       overflow;
`ifdef MAG_STATS_ALARM_EN
  logic [7:0] thr_hi = '0;
  logic [7:0] thr_lo = '0;
  logic       alarm;
`endif

  always #5 clk = ~clk;

  mag_window_stats dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_peak  (out_peak),
    .out_mean  (out_mean),
    .win_cnt   (win_cnt),
    .overflow  (overflow)
`ifdef MAG_STATS_ALARM_EN
    ,
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .alarm     (alarm)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(input string t, input int ev,
                         input int ep, input int em,
                         input int ec, input int eo);
    chk({t, "/valid"}, 32'(out_valid), ev);
    chk({t, "/peak"}, 32'(out_peak), ep);
    chk({t, "/mean"}, 32'(out_mean), em);
    chk({t, "/cnt"}, 32'(win_cnt), ec);
    chk({t, "/ovf"}, 32'(overflow), eo);
  endtask

  // ---------------- reference model ----------------
  int       win_q[$];
  mag_rec_t mq[$];
  int       m_lp, m_lm;
  bit       m_ovf;
  bit       m_al;

  function automatic void m_reset();
    win_q.delete();
    mq.delete();
    m_lp  = 0;
    m_lm  = 0;
    m_ovf = 0;
    m_al  = 0;
  endfunction

  function automatic void m_step(bit e, bit v, int d,
                                 bit r, bit c,
                                 int hi, int lo);
    mag_rec_t rc;
    int mx, s;
    if (c) begin
      m_reset();
      return;
    end
    if (mq.size() > 0 && r) begin
      rc   = mq.pop_front();
      m_lp = int'(rc.peak);
      m_lm = int'(rc.mean);
    end
    if (e && v) begin
      if (!m_al && d >= hi) m_al = 1;
      else if (m_al && d < lo) m_al = 0;
      win_q.push_back(d);
      if (win_q.size() == N) begin
        mx = 0;
        s  = 0;
        foreach (win_q[k]) begin
          s += win_q[k];
          if (win_q[k] > mx) mx = win_q[k];
        end
        rc.peak = 8'(mx);
        rc.mean = 8'(s / N);
        if (mq.size() < D) mq.push_back(rc);
        else m_ovf = 1;
        win_q.delete();
      end
    end
  endfunction

  task automatic m_check(input string t);
    int ev, ep, em;
    ev = (mq.size() > 0) ? 1 : 0;
    ep = ev ? int'(mq[0].peak) : m_lp;
    em = ev ? int'(mq[0].mean) : m_lm;
    chk_out(t, ev, ep, em, win_q.size(), int'(m_ovf));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int d, input bit r);
    ena      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'(d);
    out_ready = r;
    cyc();
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  typedef struct {
    bit    e, v, r, c;
    int    d;
    int    ev, ep, em, ec, eo;
    string nm;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit e, bit v, int d,
                              bit r, bit c, int ev,
                              int ep, int em, int ec,
                              int eo, string nm);
    vec_t x;
    x.e = e; x.v = v; x.d = d; x.r = r; x.c = c;
    x.ev = ev; x.ep = ep; x.em = em;
    x.ec = ec; x.eo = eo; x.nm = nm;
    tbl.push_back(x);
  endfunction

  initial begin
    int cnt, lastp;
    bit l7;

    for (int i = 0; i < 8; i++) begin
      l7 = (i == 7);
      add(1, 1, 10 * (i + 1), 0, 0, int'(l7),
          l7 ? 80 : 0, l7 ? 45 : 0, (i + 1) % 8, 0,
          "t1_acc");
    end
    add(0, 0, 0, 1, 0, 0, 80, 45, 0, 0, "t1_pop");
    add(0, 1, 99, 0, 0, 0, 80, 45, 0, 0, "ena0");
    for (int i = 0; i < 8; i++) begin
      l7 = (i == 7);
      add(1, 1, 255, 0, 0, int'(l7),
          l7 ? 255 : 80, l7 ? 255 : 45, (i + 1) % 8, 0,
          "t2_acc");
    end
    add(0, 0, 0, 1, 0, 0, 255, 255, 0, 0, "t2_pop");
    for (int i = 0; i < 8; i++) begin
      l7 = (i == 7);
      add(1, 1, l7 ? 9 : 0, 0, 0, int'(l7),
          l7 ? 9 : 255, l7 ? 1 : 255, (i + 1) % 8, 0,
          "trunc");
    end
    add(0, 0, 0, 1, 0, 0, 9, 1, 0, 0, "trunc_pop");
    for (int i = 0; i < 3; i++)
      add(1, 1, 50, 0, 0, 0, 9, 1, i + 1, 0, "pre_clr");
    add(1, 1, 50, 1, 1, 0, 0, 0, 0, 0, "clr");

    // reset state, checked before any clock edge
    #2;
    chk_out("reset", 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      ena       = tbl[k].e;
      in_valid  = tbl[k].v;
      in_data   = 8'(tbl[k].d);
      out_ready = tbl[k].r;
      clr       = tbl[k].c;
      cyc();
      chk_out(tbl[k].nm, tbl[k].ev, tbl[k].ep,
              tbl[k].em, tbl[k].ec, tbl[k].eo);
    end
    ena = 0; in_valid = 0; out_ready = 0; clr = 0;

    // 5 windows with no reader: 4 kept, 5th dropped
    for (int w = 0; w < 5; w++)
      for (int s = 0; s < N; s++) put(w + 1, 0);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_valid", 32'(out_valid), 1);
    for (int k = 0; k < 4; k++) begin
      chk("t3_peak", 32'(out_peak), k + 1);
      chk("t3_mean", 32'(out_mean), k + 1);
      pop1();
    end
    chk("t3_empty", 32'(out_valid), 0);
    chk("t3_hold", 32'(out_peak), 4);

    // full FIFO, last sample and pop on the same edge
    do_clr();
    chk("t4_clr_ovf", 32'(overflow), 0);
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < N; s++) put(10 + w, 0);
    for (int s = 0; s < N - 1; s++) put(20, 0);
    put(20, 1);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_head", 32'(out_peak), 11);
    cnt   = 0;
    lastp = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) begin
        lastp = int'(out_peak);
        cnt++;
        pop1();
      end
    end
    chk("t4_count", 32'(cnt), 4);
    chk("t4_last", 32'(lastp), 20);

    // partial window, frozen by ena=0, then async reset
    do_clr();
    for (int s = 0; s < 3; s++) put(200, 0);
    ena = 0; in_valid = 1; in_data = 250;
    cyc();
    in_valid = 0;
    chk("t5_frozen", 32'(win_cnt), 3);
    rst_n = 0;
    #2;
    chk("t5_rst_cnt", 32'(win_cnt), 0);
    chk("t5_rst_valid", 32'(out_valid), 0);
    cyc();
    rst_n = 1;
    for (int s = 0; s < N; s++) put(7, 0);
    chk_out("t5_rec", 1, 7, 7, 0, 0);
    pop1();

`ifdef MAG_STATS_ALARM_EN
    do_clr();
    thr_hi = 100;
    thr_lo = 50;
    put(99, 0);
    chk("alarm_99", 32'(alarm), 0);
    put(100, 0);
    chk("alarm_100", 32'(alarm), 1);
    put(60, 0);
    chk("alarm_60", 32'(alarm), 1);
    put(49, 0);
    chk("alarm_49", 32'(alarm), 0);
    thr_hi = 150;
    thr_lo = 80;
`endif

    // randomized traffic against the model
    rst_n = 0;
    m_reset();
    cyc();
    rst_n = 1;
    for (int i = 0; i < 600; i++) begin
      ena      = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      if (((i / 100) % 2) == 1)
        out_ready = ($urandom_range(0, 9) < 2);
      else
        out_ready = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 199) == 0);
      m_step(ena, in_valid, int'(in_data), out_ready,
             clr, 150, 80);
      cyc();
      m_check("rand");
`ifdef MAG_STATS_ALARM_EN
      chk("rand_alarm", 32'(alarm), 32'(m_al));
`endif
    end
    ena = 0; in_valid = 0; out_ready = 0; clr = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
